mac_sequencer: RTL

- Sequences the fixed-point multiplier for one dot product: accepts LEN (feature, weight) pairs over a valid/ready stream, multiplies each pair, and accumulates the products with saturation.
- Returns the sum over a valid/ready result port.
- Sits between the feature/weight buffers and the neuron output stage; it owns one multiplier instance, the product register and the accumulator.

---
 rtl/mac_sequencer_if.sv | 25 ++
 rtl/mac_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mac_sequencer_if.sv
// Operand and result valid/ready streams of the dot-product MAC sequencer.
interface mac_sequencer_if #(
    parameter int IF_W  = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [IF_W-1:0]  in_if;
    logic [W_W-1:0]   in_w;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_sat;

    modport master (
        output in_valid, in_if, in_w, out_ready,
        input  in_ready, out_valid, out_sum, out_sat
    );

    modport slave (
        input  in_valid, in_if, in_w, out_ready,
        output in_ready, out_valid, out_sum, out_sat
    );
endinterface

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: multiplies LEN (feature, weight) pairs and accumulates
// the (8,5) products into a saturating (16,5) accumulator.
module mac_sequencer #(
    parameter int IF_W  = 8,
    parameter int W_W   = 8,
    parameter int P_W   = 8,
    parameter int ACC_W = 16,
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    mac_sequencer_if.slave   bus
);
    localparam int RAW_W = IF_W + W_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   r_state;
    logic [LEN_W-1:0]         r_remaining;
    logic signed [P_W-1:0]    r_prod;
    logic                     r_prod_v;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_sat;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_busy;

    logic                     w_hs;
    logic signed [RAW_W-1:0]  w_feat_x;
    logic signed [RAW_W-1:0]  w_wt_x;
    logic signed [RAW_W-1:0]  w_raw;
    logic signed [P_W-1:0]    w_prod;
    logic signed [ACC_W:0]    w_sum;
    logic                     w_ovf;
    logic signed [ACC_W-1:0]  w_acc_next;

    assign w_hs = bus.in_valid && r_in_ready;

    // Feature is unsigned: zero-extend before the signed multiply; >>> gives floor.
    assign w_feat_x = RAW_W'($signed({1'b0, bus.in_if}));
    assign w_wt_x   = RAW_W'($signed(bus.in_w));
    assign w_raw    = w_feat_x * w_wt_x;
    assign w_prod   = P_W'(w_raw >>> 8);

    assign w_sum      = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_prod);
    assign w_ovf      = w_sum[ACC_W] != w_sum[ACC_W-1];
    assign w_acc_next = w_ovf ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_prod      <= '0;
            r_prod_v    <= 1'b0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_prod_v <= w_hs;
            if (w_hs)
                r_prod <= w_prod;
            if (r_prod_v) begin
                r_acc <= w_acc_next;
                if (w_ovf)
                    r_sat <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= '0;
                        r_sat  <= 1'b0;
                        r_busy <= 1'b1;
                        if (len != '0) begin
                            r_state     <= S_RUN;
                            r_remaining <= len;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_DRAIN;
                        end
                    end
                end
                // Leave only once the last product has been folded into r_acc.
                S_DRAIN: begin
                    if (!r_prod_v) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_acc;
    assign bus.out_sat   = r_sat;
endmodule
